data_sram_like_bridge: RTL and testbench
========================================

# data_sram_like_bridge

Converts the core's memory-stage data access into a sram-like split-transaction request (req / addr_ok / data_ok). It sits directly downstream of the core's M-stage memory port, between the core and the sram-like-to-AXI interconnect. It holds the core in `dataStall` until the access completes. It also keeps a completed load's data stable while the pipeline stays frozen for any other reason (`longest_stall`).

## Interface
Parameters:
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width. Only 32 is supported.

Ports (clock and reset first):
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-high reset.
- `mem_enM` in 1: M-stage access valid.
- `mem_wenM` in 4: byte write enables; all zeros means a load.
- `aluoutM` in ADDR_W: access address.
- `mem_write_dataM` in DATA_W: store data, already byte-lane aligned.
- `readdataM` out DATA_W: load data returned to the core.
- `longest_stall` in 1: global pipeline freeze, from any source.
- `dataStall` out 1: the data access is not yet complete.
- `data_req` out 1: sram-like request.
- `data_wr` out 1: 1 for a store.
- `data_size` out 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` out ADDR_W: request address.
- `data_wdata` out DATA_W: request write data.
- `data_addr_ok` in 1: request accepted.
- `data_data_ok` in 1: response valid (read data, or write acknowledge).
- `data_rdata` in DATA_W: read data.

## Operation
- FSM states:
  - IDLE: no outstanding access.
  - REQ: `data_req` asserted, waiting for `data_addr_ok`.
  - WAIT: accepted, waiting for `data_data_ok`.
  - DONE: access finished, holding the result until the pipeline advances.
- IDLE transitions on `mem_enM`:
  - `data_req` = 1 combinationally in the same cycle.
  - `addr_ok` & `data_ok` → DONE.
  - `addr_ok` only → WAIT.
  - neither → REQ.
- REQ: `data_req` stays 1. `addr_ok` & `data_ok` → DONE; `addr_ok` → WAIT.
- WAIT: `data_req` = 0. `data_ok` → DONE, and `data_rdata` is latched into `rdata_r`.
- DONE: `data_req` = 0.
  - `longest_stall` = 0 → IDLE.
  - Otherwise stay in DONE. No re-issue, even though `mem_enM` is still 1.
- `data_addr`, `data_wdata` and `data_wr` are combinational passthroughs of the M-stage inputs. The inputs are stable because the core is stalled. `data_wr = |mem_wenM`.
- `data_size` mapping:
  - 4'b1111 → 2.
  - 4'b0011 or 4'b1100 → 1.
  - a single bit set → 0.
  - load → 2. The core extracts bytes and halves itself.
- `dataStall = mem_enM & (state != DONE)`. It is forced to 0 while `rst` is high.
- `readdataM = rdata_r`.
- A `data_ok` seen in IDLE or REQ without a prior acceptance is ignored.
- A store captures no data. `rdata_r` keeps its old value.

## Timing
- Reset values: state IDLE, `rdata_r` 0, `data_req` 0, `dataStall` 0, `readdataM` 0.
- Minimum latency, with `addr_ok` and `data_ok` both high in the request cycle: `dataStall` is high in the request cycle and low in the next cycle. That is one stall cycle.
- General latency: the stall lasts from the request cycle through the `data_ok` cycle. It drops in the cycle after `data_ok`.
- Reset mid-operation: returns to IDLE immediately. Any later `data_ok` for the abandoned access is ignored.
- A `longest_stall` that is high only because of `dataStall` falls when the bridge reaches DONE. The FSM then leaves DONE one cycle later, so back-to-back M-stage accesses are handled without loss.

## Configuration
- `DATA_BRIDGE_RDATA_BYPASS_EN`:
  - Defined: in the `data_ok` cycle, `readdataM = data_rdata` and `dataStall` = 0. This saves one stall cycle. In DONE, `rdata_r` is used.
  - Undefined: the registered behaviour above.

## Structure
- Shared package `bridge_pkg` holds:
  - the FSM state enum, encoded IDLE=0, REQ=1, WAIT=2, DONE=3;
  - the size constants SIZE_BYTE / SIZE_HALF / SIZE_WORD.
- One sub-module, `wen_to_size`: purely combinational, mapping 4-bit wen to 2-bit size.

## Test plan
- Load with `addr` 0xBFC0_0010, `addr_ok` and `data_ok` both in the request cycle, `rdata` 0x1234_5678:
  - `dataStall` is 1 for one cycle;
  - `readdataM` = 0x1234_5678;
  - `data_size` = 2 and `data_wr` = 0.
- Store with wen 4'b0100 and data 0x00AB_0000, `addr_ok` after 3 cycles, `data_ok` 2 cycles later:
  - `data_req` is held for 4 cycles;
  - `data_size` = 0 and `data_wr` = 1;
  - stall drops in the cycle after `data_ok`.
- Load completes while `longest_stall` is held high for 5 extra cycles:
  - `data_req` stays 0 with no re-issue;
  - `readdataM` stays stable.
- Back-to-back loads to 0x100 and 0x104: two distinct requests, each with correct data.
- Assert `rst` while in WAIT, then pulse `data_ok`: the state stays IDLE and `readdataM` = 0.
- With `DATA_BRIDGE_RDATA_BYPASS_EN` defined, `data_ok` arriving 2 cycles after `addr_ok`:
  - `dataStall` is 0 in the `data_ok` cycle;
  - `readdataM` equals `data_rdata` in that cycle.

Source files
------------

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Shared types and constants for the data-side sram-like
//               bridge: FSM state encoding and sram-like transfer sizes.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

  // Access FSM state, explicitly 2 bits wide.
  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no outstanding access
    REQ  = 2'd1,  // request driven, waiting for addr_ok
    WAIT = 2'd2,  // accepted, waiting for data_ok
    DONE = 2'd3   // finished, holding result until the pipeline advances
  } state_t;

  // sram-like data_size encoding.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

endpackage : bridge_pkg
`default_nettype wire

// File: rtl/wen_to_size.sv
`default_nettype none
// ============================================================================
// Module      : wen_to_size
// Description : Maps the core's 4-bit byte write enable to an sram-like
//               transfer size. Loads (all-zero enable) request a full word;
//               the core extracts bytes and halves itself.
// Ports       : i_wen  [3:0] byte write enables
//               o_size [1:0] SIZE_BYTE / SIZE_HALF / SIZE_WORD
// Revision    : 1.0 - initial release
// ============================================================================
module wen_to_size
  import bridge_pkg::*;
(
  input  logic [3:0] i_wen,
  output logic [1:0] o_size
);

  always_comb begin
    o_size = SIZE_WORD;
    case (i_wen)
      4'b1111:                            o_size = SIZE_WORD;
      4'b0011, 4'b1100:                   o_size = SIZE_HALF;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: o_size = SIZE_BYTE;
      default:                            o_size = SIZE_WORD;  // load
    endcase
  end

endmodule : wen_to_size
`default_nettype wire

// File: rtl/data_sram_like_bridge.sv
`default_nettype none
// ============================================================================
// Module      : data_sram_like_bridge
// Description : Turns the core's M-stage data access into an sram-like
//               split transaction (req / addr_ok / data_ok). Stalls the core
//               via dataStall until the access completes and keeps load data
//               stable while the pipeline is frozen by longest_stall.
// Config      : DATA_BRIDGE_RDATA_BYPASS_EN - when defined, load data is
//               forwarded combinationally in the data_ok cycle and the stall
//               is released in that same cycle.
// Ports       : clk, rst (async, active high)
//               mem_enM, mem_wenM, aluoutM, mem_write_dataM : M-stage access
//               readdataM       : load data to the core
//               longest_stall   : global pipeline freeze
//               dataStall       : access not yet complete
//               data_req/wr/size/addr/wdata : sram-like request
//               data_addr_ok/data_ok/rdata  : sram-like responses
// Revision    : 1.0 - initial release
// ============================================================================
module data_sram_like_bridge
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_enM,
  input  logic [3:0]        mem_wenM,
  input  logic [ADDR_W-1:0] aluoutM,
  input  logic [DATA_W-1:0] mem_write_dataM,
  output logic [DATA_W-1:0] readdataM,
  input  logic              longest_stall,
  output logic              dataStall,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  state_t            r_state;
  state_t            w_next;
  state_t            w_done_target;
  logic [DATA_W-1:0] r_rdata;
  logic              w_issue;
  logic              w_complete;
  logic              w_is_load;

  // The core holds the M-stage inputs stable while stalled, so the request
  // fields pass straight through.
  assign data_addr  = aluoutM;
  assign data_wdata = mem_write_dataM;
  assign data_wr    = |mem_wenM;
  assign w_is_load  = ~|mem_wenM;

  wen_to_size u_wen_to_size (
    .i_wen  (mem_wenM),
    .o_size (data_size)
  );

  // Request is live in IDLE (new access) and in REQ (not yet accepted).
  assign w_issue = ((r_state == IDLE) && mem_enM) || (r_state == REQ);

  // A data_ok only counts once the access has been accepted, either in an
  // earlier cycle (WAIT) or in this very cycle together with addr_ok.
  assign w_complete = (w_issue && data_addr_ok && data_data_ok) ||
                      ((r_state == WAIT) && data_data_ok);

`ifdef DATA_BRIDGE_RDATA_BYPASS_EN
  // The stall already drops in the data_ok cycle, so the pipeline may advance
  // on that same edge; going straight to IDLE then lets the next access issue
  // instead of being swallowed by a DONE cycle the core never waits for.
  assign w_done_target = longest_stall ? DONE : IDLE;
`else
  assign w_done_target = DONE;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (mem_enM) begin
          if (data_addr_ok && data_data_ok) w_next = w_done_target;
          else if (data_addr_ok)            w_next = WAIT;
          else                              w_next = REQ;
        end
      end
      REQ: begin
        if (data_addr_ok && data_data_ok) w_next = w_done_target;
        else if (data_addr_ok)            w_next = WAIT;
      end
      WAIT: begin
        if (data_data_ok) w_next = w_done_target;
      end
      DONE: begin
        // No re-issue while frozen, even though mem_enM is still high.
        if (!longest_stall) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Load data capture; stores leave the previous value untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (w_complete && w_is_load) begin
      r_rdata <= data_rdata;
    end
  end

  // Output logic. Nothing is requested or stalled while reset is asserted.
  always_comb begin
    data_req  = w_issue && !rst;
`ifdef DATA_BRIDGE_RDATA_BYPASS_EN
    dataStall = mem_enM && (r_state != DONE) && !w_complete && !rst;
    readdataM = (w_complete && w_is_load) ? data_rdata : r_rdata;
`else
    dataStall = mem_enM && (r_state != DONE) && !rst;
    readdataM = r_rdata;
`endif
  end

endmodule : data_sram_like_bridge
`default_nettype wire

// File: tb/tb_data_sram_like_bridge.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_sram_like_bridge
// Description : Directed self-checking bench for data_sram_like_bridge.
//               Load data expectations go through a scoreboard queue.
//               Honours DATA_BRIDGE_RDATA_BYPASS_EN if defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_sram_like_bridge;

`ifdef DATA_BRIDGE_RDATA_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enM;
  logic [3:0]  mem_wenM;
  logic [31:0] aluoutM;
  logic [31:0] mem_write_dataM;
  logic [31:0] readdataM;
  logic        longest_stall;
  logic        dataStall;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        extra;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_load = 32'h0;

  // The core's freeze includes our own stall plus any other source.
  assign longest_stall = dataStall | extra;

  always #5 clk = ~clk;

  data_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .mem_enM         (mem_enM),
    .mem_wenM        (mem_wenM),
    .aluoutM         (aluoutM),
    .mem_write_dataM (mem_write_dataM),
    .readdataM       (readdataM),
    .longest_stall   (longest_stall),
    .dataStall       (dataStall),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access. Inputs are applied at the start of each cycle and
  // outputs sampled 1ns later, well away from the rising edge.
  task automatic access(input logic [31:0] addr, input logic [3:0] wen,
                        input logic [31:0] wdata, input int aok_dly,
                        input int dok_dly, input logic [31:0] rdata,
                        input logic [1:0] exp_size, input int hold);
    int          req_seen;
    int          stall_seen;
    bit          is_load;
    logic [31:0] exp_rd;
    req_seen   = 0;
    stall_seen = 0;
    is_load    = (wen == 4'b0000);
    mem_enM = 1'b1; mem_wenM = wen; aluoutM = addr; mem_write_dataM = wdata;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'hDEAD_BEEF;
    for (int c = 0; c < aok_dly; c++) begin
      #1;
      req_seen += int'(data_req); stall_seen += int'(dataStall);
      step();
    end
    // acceptance cycle
    data_addr_ok = 1'b1;
    data_data_ok = (dok_dly == 0);
    if (dok_dly == 0) begin
      data_rdata = rdata;
      if (is_load) sb_q.push_back(rdata);
      if (hold > 0) extra = 1'b1;
    end
    #1;
    req_seen += int'(data_req); stall_seen += int'(dataStall);
    chk("addr", data_addr, addr);
    chk("wdata", data_wdata, wdata);
    chk("wr", {31'b0, data_wr}, {31'b0, !is_load});
    chk("size", {30'b0, data_size}, {30'b0, exp_size});
    if (dok_dly == 0 && BYP == 1 && is_load) chk("bypass_rdata", readdataM, rdata);
    step();
    data_addr_ok = 1'b0;
    for (int c = 1; c <= dok_dly; c++) begin
      data_data_ok = (c == dok_dly);
      data_rdata   = (c == dok_dly) ? rdata : 32'hDEAD_BEEF;
      if (c == dok_dly) begin
        if (is_load) sb_q.push_back(rdata);
        if (hold > 0) extra = 1'b1;
      end
      #1;
      req_seen += int'(data_req); stall_seen += int'(dataStall);
      if (c == dok_dly && BYP == 1) begin
        chk("bypass_stall", {31'b0, dataStall}, 32'h0);
        if (is_load) chk("bypass_rdata", readdataM, rdata);
      end
      step();
    end
    data_data_ok = 1'b0;
    data_rdata   = 32'hDEAD_BEEF;
    chk("req_cycles", req_seen, aok_dly + 1);
    chk("stall_cycles", stall_seen, aok_dly + 1 + dok_dly - BYP);
    exp_rd = is_load ? sb_q.pop_front() : last_load;
    if (is_load) last_load = exp_rd;
    if (BYP == 0 || hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        #1;
        chk("frozen_req", {31'b0, data_req}, 32'h0);
        chk("frozen_stall", {31'b0, dataStall}, 32'h0);
        chk("frozen_rdata", readdataM, exp_rd);
        step();
      end
      extra = 1'b0;
      #1;
      chk("done_stall", {31'b0, dataStall}, 32'h0);
      chk("done_req", {31'b0, data_req}, 32'h0);
      chk("done_rdata", readdataM, exp_rd);
      step();
    end else begin
      #1;
      chk("held_rdata", readdataM, exp_rd);
    end
  endtask

  initial begin
    rst = 1'b1; mem_enM = 1'b1; mem_wenM = 4'h0; aluoutM = 32'h0;
    mem_write_dataM = 32'h0; extra = 1'b0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    step(); step();
    chk("rst_stall", {31'b0, dataStall}, 32'h0);
    chk("rst_req", {31'b0, data_req}, 32'h0);
    chk("rst_rdata", readdataM, 32'h0);
    mem_enM = 1'b0; rst = 1'b0;
    step();

    // minimum-latency load
    access(32'hBFC0_0010, 4'b0000, 32'h0, 0, 0, 32'h1234_5678, 2'd2, 0);
    mem_enM = 1'b0; step();

    // byte store with delayed handshakes
    access(32'h0000_2002, 4'b0100, 32'h00AB_0000, 3, 2, 32'h5555_AAAA, 2'd0, 0);
    mem_enM = 1'b0; step();

    // half store, then load frozen for 5 extra cycles
    access(32'h0000_2000, 4'b1100, 32'hBEEF_0000, 0, 1, 32'h0, 2'd1, 0);
    access(32'h0000_0200, 4'b0000, 32'h0, 1, 1, 32'hA5A5_0F0F, 2'd2, 5);
    mem_enM = 1'b0; step();

    // back-to-back loads
    access(32'h0000_0100, 4'b0000, 32'h0, 1, 1, 32'h1111_0100, 2'd2, 0);
    access(32'h0000_0104, 4'b0000, 32'h0, 0, 2, 32'h2222_0104, 2'd2, 0);
    mem_enM = 1'b0; step();

    // reset while in WAIT, then a stray data_ok
    mem_enM = 1'b1; mem_wenM = 4'h0; aluoutM = 32'h0000_0300; data_addr_ok = 1'b1;
    #1; step();
    data_addr_ok = 1'b0;
    #1;
    chk("wait_stall", {31'b0, dataStall}, 32'h1);
    chk("wait_req", {31'b0, data_req}, 32'h0);
    rst = 1'b1;
    #1;
    chk("midrst_stall", {31'b0, dataStall}, 32'h0);
    chk("midrst_rdata", readdataM, 32'h0);
    step();
    rst = 1'b0; mem_enM = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_BABE;
    #1; step();
    data_data_ok = 1'b0; mem_enM = 1'b1;
    #1;
    chk("post_rst_idle_req", {31'b0, data_req}, 32'h1);
    chk("post_rst_rdata", readdataM, 32'h0);
    mem_enM = 1'b0;
    step(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_data_sram_like_bridge
`default_nettype wire
